mm_bus_master: RTL and testbench

MM_BUS_MASTER -- requirements
Module: mm_bus_master

---
 rtl/mm_bus_master_if.sv | 33 +++
 rtl/mm_bus_master.sv | 148 ++++++++++++++
 tb/tb_mm_bus_master.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mm_bus_master_if.sv
// Signal bundle between the local initiator, mm_bus_master and the shared memory-mapped bus.
// The master modport is the bus master's view; slave is the view of whatever drives it.
interface mm_bus_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        bus_write_o;
    logic        bus_read_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  rsp_ready_i, bus_rdata_i, bus_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output bus_write_o, bus_read_o, bus_addr_o, bus_wdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output rsp_ready_i, bus_rdata_i, bus_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  bus_write_o, bus_read_o, bus_addr_o, bus_wdata_o
    );
endinterface

// File: rtl/mm_bus_master.sv
// Single-outstanding memory-mapped bus master: accepts one command, strobes the bus until
// ack or timeout, then holds the response until the initiator takes it.
module mm_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mm_bus_master_if.master      bus_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        bus_write_q, bus_write_d;
    logic        bus_read_q, bus_read_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    // Next-state, command latch, timeout counter and response capture.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus_if.cmd_valid_i && cmd_ready_q) begin
                    write_d = bus_if.cmd_write_i;
                    addr_d  = bus_if.cmd_addr_i;
                    wdata_d = bus_if.cmd_wdata_i;
                    cnt_d   = 8'd0;
                    state_d = BUS;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                // Ack is tested first so an ack on the last permitted cycle beats the timeout.
                if (bus_if.bus_ack_i == 1'b1) begin
                    rsp_rdata_d = write_q ? 32'd0 : bus_if.bus_rdata_i;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = BUS;
                end
            end
            RESP: begin
                if (rsp_valid_q && bus_if.rsp_ready_i) begin
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_rdata_d = 32'd0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // Output registers are loaded from the upcoming state so they change together with it.
    always_comb begin
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        bus_write_d = 1'b0;
        bus_read_d  = 1'b0;
        bus_addr_d  = 32'd0;
        bus_wdata_d = 32'd0;
        if (state_d == BUS) begin
            bus_write_d = write_d;
            bus_read_d  = ~write_d;
            bus_addr_d  = addr_d;
            bus_wdata_d = wdata_d;
        end else begin
            cmd_ready_d = (state_d == IDLE);
            rsp_valid_d = (state_d == RESP);
        end
    end

    // State, holding and output registers; reset drops everything, including a pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            cnt_q       <= 8'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            bus_write_q <= 1'b0;
            bus_read_q  <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            bus_write_q <= bus_write_d;
            bus_read_q  <= bus_read_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign bus_if.cmd_ready_o = cmd_ready_q;
    assign bus_if.rsp_valid_o = rsp_valid_q;
    assign bus_if.rsp_rdata_o = rsp_rdata_q;
    assign bus_if.rsp_err_o   = rsp_err_q;
    assign bus_if.bus_write_o = bus_write_q;
    assign bus_if.bus_read_o  = bus_read_q;
    assign bus_if.bus_addr_o  = bus_addr_q;
    assign bus_if.bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mm_bus_master.sv
// Self-checking bench for mm_bus_master: a vector table of transactions with a response
// scoreboard, plus hand-written reset sequences.
module tb_mm_bus_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mm_bus_master_if bif ();

    mm_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_cycle;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_strobes;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bif.cmd_valid_i = 1'b0;
        bif.cmd_write_i = 1'b0;
        bif.cmd_addr_i  = 32'd0;
        bif.cmd_wdata_i = 32'd0;
        bif.rsp_ready_i = 1'b0;
        bif.bus_rdata_i = 32'd0;
        bif.bus_ack_i   = 1'b0;
    endtask

    // One full transaction; entered and left at a negedge.
    task automatic run_txn(input vec_t v);
        int   w;
        int   cyc;
        int   strobes;
        rsp_t e;
        e.err   = v.exp_err;
        e.rdata = v.exp_rdata;
        exp_q.push_back(e);
        bif.cmd_valid_i = 1'b1;
        bif.cmd_write_i = v.write;
        bif.cmd_addr_i  = v.addr;
        bif.cmd_wdata_i = v.wdata;
        w = 0;
        while (!bif.cmd_ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready_before_accept", {31'd0, bif.cmd_ready_o}, 32'd1);
        @(negedge clk);
        bif.cmd_valid_i = 1'b0;
        bif.cmd_write_i = ~v.write;
        bif.cmd_addr_i  = 32'hFFFF_0000;
        bif.cmd_wdata_i = 32'h1234_5678;
        check("cmd_ready_in_bus", {31'd0, bif.cmd_ready_o}, 32'd0);
        strobes = 0;
        cyc     = 0;
        while (!bif.rsp_valid_o && cyc < 40) begin
            bif.bus_ack_i   = 1'b0;
            bif.bus_rdata_i = $urandom;
            if (bif.bus_read_o || bif.bus_write_o) begin
                strobes++;
                check("bus_write", {31'd0, bif.bus_write_o}, {31'd0, v.write});
                check("bus_read", {31'd0, bif.bus_read_o}, {31'd0, ~v.write});
                check("bus_addr", bif.bus_addr_o, v.addr);
                if (v.write) check("bus_wdata", bif.bus_wdata_o, v.wdata);
                if (strobes == v.ack_cycle) begin
                    bif.bus_ack_i   = 1'b1;
                    bif.bus_rdata_i = v.write ? 32'hFFFF_FFFF : v.rdata;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bif.bus_ack_i   = 1'b0;
        bif.bus_rdata_i = 32'hA5A5_A5A5;
        check("strobe_cycles", strobes, v.exp_strobes);
        check("rsp_latency", cyc, v.exp_strobes);
        check("rsp_valid", {31'd0, bif.rsp_valid_o}, 32'd1);
        check("strobes_off_in_resp", {30'd0, bif.bus_read_o, bif.bus_write_o}, 32'd0);
        check("bus_addr_off_in_resp", bif.bus_addr_o, 32'd0);
        for (int h = 0; h < v.hold; h++) begin
            check("hold_valid", {31'd0, bif.rsp_valid_o}, 32'd1);
            check("hold_rdata", bif.rsp_rdata_o, exp_q[0].rdata);
            check("hold_err", {31'd0, bif.rsp_err_o}, {31'd0, exp_q[0].err});
            check("hold_cmd_ready", {31'd0, bif.cmd_ready_o}, 32'd0);
            @(negedge clk);
        end
        bif.rsp_ready_i = 1'b1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_rdata", bif.rsp_rdata_o, e.rdata);
            check("rsp_err", {31'd0, bif.rsp_err_o}, {31'd0, e.err});
        end else begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end
        @(negedge clk);
        bif.rsp_ready_i = 1'b0;
        check("rsp_valid_after_hs", {31'd0, bif.rsp_valid_o}, 32'd0);
        check("cmd_ready_after_hs", {31'd0, bif.cmd_ready_o}, 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        int seen_valid;
        vecs[0] = '{1'b1, 32'h4000_0000, 32'h0000_02AA, 32'h0, 1, 0, 1'b0, 32'h0, 1};
        vecs[1] = '{1'b0, 32'h4000_0000, 32'hDEAD_0000, 32'h0000_02AA, 1, 0, 1'b0, 32'h0000_02AA, 1};
        vecs[2] = '{1'b0, 32'h5000_0000, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 16};
        vecs[3] = '{1'b0, 32'h4000_0010, 32'h0, 32'hDEAD_BEEF, 16, 0, 1'b0, 32'hDEAD_BEEF, 16};
        vecs[4] = '{1'b1, 32'h4000_0020, 32'h0BAD_F00D, 32'h0, 16, 1, 1'b0, 32'h0, 16};
        vecs[5] = '{1'b0, 32'h4000_0030, 32'h0, 32'hCAFE_0001, 15, 5, 1'b0, 32'hCAFE_0001, 15};
        vecs[6] = '{1'b1, 32'h5000_0004, 32'h5555_AAAA, 32'h0, 0, 2, 1'b1, 32'h0, 16};
        vecs[7] = '{1'b0, 32'h4000_0040, 32'h0, 32'h8000_0001, 3, 2, 1'b0, 32'h8000_0001, 3};

        drive_idle();
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, bif.cmd_ready_o}, 32'd0);
        check("rst_rsp_valid", {31'd0, bif.rsp_valid_o}, 32'd0);
        check("rst_strobes", {30'd0, bif.bus_read_o, bif.bus_write_o}, 32'd0);
        check("rst_rsp_rdata", bif.rsp_rdata_o, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, bif.cmd_ready_o}, 32'd1);

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Reset while a read is waiting on the bus: strobes drop at once, no response appears.
        @(negedge clk);
        bif.cmd_valid_i = 1'b1;
        bif.cmd_write_i = 1'b0;
        bif.cmd_addr_i  = 32'h5000_0000;
        @(negedge clk);
        bif.cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_bus_read", {31'd0, bif.bus_read_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_strobes", {30'd0, bif.bus_read_o, bif.bus_write_o}, 32'd0);
        check("async_addr", bif.bus_addr_o, 32'd0);
        check("async_cmd_ready", {31'd0, bif.cmd_ready_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bif.rsp_valid_o) seen_valid++;
        end
        check("no_rsp_after_reset", seen_valid, 0);
        check("scoreboard_empty_mid", exp_q.size(), 0);
        run_txn(vecs[1]);
        run_txn(vecs[0]);

        check("scoreboard_empty_end", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
